// File: rtl/muldiv_seq.sv
// Multi-cycle HI/LO sequencer for the EX stage: fixed-latency external multiplier
// control plus an internal restoring divider, with pipeline stall and one-cycle done.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; accepts an op when start & ~flush
// S_MUL   | counting down the external multiplier latency
// S_DIV   | one restoring-division step per cycle, quotient MSB first
// S_FIX   | applying quotient/remainder signs, writing hi/lo
// S_DONE  | done pulse, stall released; returns to idle unconditionally
module muldiv_seq #(
    parameter int DATA_W   = 32,
    parameter int MULT_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op_div,
    input  logic                  op_sign,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     rs,
    input  logic [DATA_W-1:0]     rt,
    input  logic [2*DATA_W-1:0]   mul_prod,
    output logic [DATA_W-1:0]     mul_a,
    output logic [DATA_W-1:0]     mul_b,
    output logic                  mul_sign,
    output logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_W-1:0]     hi,
    output logic [DATA_W-1:0]     lo,
    output logic                  div_by_zero
);

    localparam int CNT_MAX = (DATA_W > MULT_LAT) ? DATA_W : MULT_LAT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] dvsr;
    logic              q_neg;
    logic              r_neg;

    logic              accept;
    logic              rt_zero;
    logic              cnt_zero;
    logic [DATA_W-1:0] rs_mag;
    logic [DATA_W-1:0] rt_mag;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   trial;
    logic              trial_ok;

    assign accept   = (state == S_IDLE) && start && !flush;
    assign rt_zero  = (rt == '0);
    assign cnt_zero = (cnt == '0);

    assign rs_mag = (op_sign && rs[DATA_W-1]) ? (~rs + 1'b1) : rs;
    assign rt_mag = (op_sign && rt[DATA_W-1]) ? (~rt + 1'b1) : rt;

    // Partial remainder is always below the divisor, so one extra bit holds the shift.
    assign shifted  = {rem, quo[DATA_W-1]};
    assign trial    = shifted - {1'b0, dvsr};
    assign trial_ok = (shifted >= {1'b0, dvsr});

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        case (state)
            S_IDLE: begin
                if (accept) begin
                    stall = 1'b1;
                    if (!op_div) begin
                        state_nx = S_MUL;
                    end else if (rt_zero) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_DIV;
                    end
                end
            end
            S_MUL: begin
                stall = 1'b1;
                if (flush) begin
                    state_nx = S_IDLE;
                end else if (cnt_zero) begin
                    state_nx = S_DONE;
                end
            end
            S_DIV: begin
                stall = 1'b1;
                if (flush) begin
                    state_nx = S_IDLE;
                end else if (cnt_zero) begin
                    state_nx = S_FIX;
                end
            end
            S_FIX: begin
                stall = 1'b1;
                if (flush) begin
                    state_nx = S_IDLE;
                end else begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dvsr        <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            mul_sign    <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mul_a       <= rs;
                        mul_b       <= rt;
                        mul_sign    <= op_sign;
                        div_by_zero <= 1'b0;
                        cnt         <= op_div ? CNT_W'(DATA_W - 1) : CNT_W'(MULT_LAT - 1);
                        rem         <= '0;
                        quo         <= rs_mag;
                        dvsr        <= rt_mag;
                        q_neg       <= op_sign && (rs[DATA_W-1] ^ rt[DATA_W-1]);
                        r_neg       <= op_sign && rs[DATA_W-1];
                        if (op_div && rt_zero) begin
                            lo          <= '1;
                            hi          <= rs;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    if (!flush) begin
                        cnt <= cnt - 1'b1;
                        if (cnt_zero) begin
                            {hi, lo} <= mul_prod;
                        end
                    end
                end
                S_DIV: begin
                    if (!flush) begin
                        cnt <= cnt - 1'b1;
                        if (trial_ok) begin
                            rem <= trial[DATA_W-1:0];
                            quo <= {quo[DATA_W-2:0], 1'b1};
                        end else begin
                            rem <= shifted[DATA_W-1:0];
                            quo <= {quo[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        lo <= q_neg ? (~quo + 1'b1) : quo;
                        hi <= r_neg ? (~rem + 1'b1) : rem;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
